exception_unit: RTL and testbench
=================================

Name: exception_unit

Overview:
- Exception/interrupt sequencer for the multicycle CPU. Sits directly upstream of the exception-target register.
- Decides when an exception is taken and produces that register's write strobe and 5-bit target index. Also produces the saved return address and the PC redirect to the handler vector.
- Tracks kernel mode, masks nested IRQs and handles return-from-handler.

Parameters:
- K0_REG, 5'd26: register index written with the return address on exception entry.
- ILLOP_VEC, 32'h8000_0004: handler vector for undefined instruction.
- XADR_VEC, 32'h8000_0008: handler vector for external interrupt.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- irq  in  1  asynchronous interrupt request from timer/peripheral (level)
- undef_inst  in  1  decode-stage pulse: current instruction is illegal
- instr_boundary  in  1  high for one cycle when the main FSM completes an instruction
- eret  in  1  pulse: return-from-handler instruction executes
- pc_plus4  in  32  PC+4 of the current instruction
- er_write  out  1  write strobe to the exception-target register
- er_o  out  5  target register index
- epc_o  out  32  latched return address (write data for K0_REG)
- pc_redirect  out  1  one-cycle strobe: load PC with handler_pc
- handler_pc  out  32  vector address
- kernel_mode  out  1  high while in handler
- abort_inst  out  1  one-cycle strobe: main FSM discards current instruction and refetches

Behaviour:
- Reset (async, takes effect immediately):
  - state=USER; all strobes 0; er_o=0; epc_o=0; handler_pc=0; kernel_mode=0.
  - Sync flops and the pending latch are cleared.
- IRQ path:
  - irq passes through a 2-flop synchroniser; irq_s is the second flop's output.
  - irq_pend sets on irq_s=1.
  - irq_pend clears only when the IRQ is taken. A deasserted irq never clears it.
- States: USER, TAKE, KERNEL.
- USER:
  - undef_inst=1 → TAKE with cause=ILLOP and epc_o<=pc_plus4. undef_inst has priority over any pending IRQ in the same cycle.
  - Otherwise instr_boundary=1 and irq_pend=1 → TAKE with cause=XADR, epc_o<=pc_plus4, irq_pend cleared.
- TAKE (exactly one cycle):
  - er_write=1, er_o=K0_REG, pc_redirect=1, handler_pc=vector for cause.
  - abort_inst=1 only when cause=ILLOP.
  - Next state KERNEL; kernel_mode rises on entry to KERNEL.
- KERNEL:
  - irq_pend keeps latching but is masked.
  - undef_inst in KERNEL → TAKE with cause=ILLOP. Nested; epc_o overwritten.
  - eret=1 → USER next cycle; kernel_mode falls.
  - eret and undef_inst in the same cycle → undef wins.
- Returning to USER with irq_pend already set: the IRQ is taken at the next instr_boundary in USER, never in the eret cycle itself.
- er_o holds K0_REG after the first exception until reset. er_write is the only qualifier.
- Exception entry latency:
  - Undef: TAKE strobes appear the cycle after undef_inst.
  - IRQ: 2 sync cycles + pend cycle, then wait for instr_boundary; TAKE is the cycle after that boundary.
- instr_boundary during TAKE is ignored.
- Reset mid-TAKE aborts the strobes immediately.

Decomposition:
- Shared package holds:
  - state encoding (USER/TAKE/KERNEL);
  - cause encoding (ILLOP=0, XADR=1);
  - vector constants and K0_REG, so the PC-select mux and register file use identical values.
- One natural sub-module: irq_sync (2-flop synchroniser with async reset).

Test Plan:
- Reset check: reset asserted mid-run → all outputs 0 in the same cycle, state USER; after release, no strobe without a stimulus.
- Undef in USER: undef_inst=1 with pc_plus4=0x0000_0044 → next cycle:
  - er_write=1, er_o=26, epc_o=0x44;
  - handler_pc=0x8000_0004, pc_redirect=1, abort_inst=1;
  - kernel_mode=1 the cycle after.
- IRQ wait for boundary: irq raised, instr_boundary held low for 10 cycles → no strobe. Pulse instr_boundary with pc_plus4=0x100 → next cycle:
  - handler_pc=0x8000_0008, epc_o=0x100, abort_inst=0.
- IRQ masked in kernel: irq pulses while in KERNEL → no TAKE. eret, then instr_boundary with pc_plus4=0x200 → TAKE with XADR, epc_o=0x200, not in the eret cycle.
- Same-cycle priority: undef_inst=1 while irq_pend=1 and instr_boundary=1 → cause ILLOP (vector 0x8000_0004); irq_pend still set. After eret, the IRQ is taken at the next boundary.
- Nested undef in kernel: undef_inst=1 while in KERNEL with pc_plus4=0x8000_0010 → TAKE, epc_o=0x8000_0010, state returns to KERNEL.

Source files
------------

// File: rtl/exception_unit_pkg.sv
// ---------------------------------------------------------------------------
// exception_unit_pkg
//   Shared definitions for the exception/interrupt sequencer of the multicycle
//   CPU. The register file, the PC-select mux and the sequencer all import
//   this package so they agree on the register index and the vector values.
//
//   Contents:
//     state_t      - sequencer state encoding (USER / TAKE / KERNEL)
//     cause_t      - exception cause encoding (ILLOP = 0, XADR = 1)
//     K0_REG       - register that receives the return address on entry
//     ILLOP_VEC    - handler vector for an undefined instruction
//     XADR_VEC     - handler vector for an external interrupt
//     vector_for() - maps a cause onto its handler vector
// ---------------------------------------------------------------------------
package exception_unit_pkg;

  localparam logic [4:0]  K0_REG    = 5'd26;
  localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC  = 32'h8000_0008;

  typedef enum logic [1:0] {
    USER   = 2'd0,
    TAKE   = 2'd1,
    KERNEL = 2'd2
  } state_t;

  typedef enum logic {
    ILLOP = 1'b0,
    XADR  = 1'b1
  } cause_t;

  function automatic logic [31:0] vector_for(input cause_t cause);
    logic [31:0] vec;
    vec = ILLOP_VEC;
    if (cause == XADR) begin
      vec = XADR_VEC;
    end
    return vec;
  endfunction

endpackage

// File: rtl/exception_unit_irq_sync.sv
// ---------------------------------------------------------------------------
// exception_unit_irq_sync
//   Two-flop synchroniser bringing the asynchronous interrupt request into the
//   clk domain. Both flops clear on reset so no stale request survives it.
//
//   Ports:
//     clk    in   system clock
//     reset  in   asynchronous, active-high reset
//     d      in   asynchronous level input
//     q      out  synchronised level (second flop)
// ---------------------------------------------------------------------------
module exception_unit_irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its source; with = the two stages would collapse
  // into a single flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/exception_unit.sv
// ---------------------------------------------------------------------------
// exception_unit
//   Exception/interrupt sequencer for the multicycle CPU. Decides when an
//   exception is taken, strobes the exception-target register write, saves
//   the return address and redirects the PC to the handler vector. Tracks
//   kernel mode, masks interrupts while in a handler and handles eret.
//
//   Ports:
//     clk             in   system clock
//     reset           in   asynchronous, active-high reset
//     irq             in   asynchronous interrupt request (level)
//     undef_inst      in   decode pulse: current instruction is illegal
//     instr_boundary  in   one-cycle pulse when an instruction completes
//     eret            in   pulse: return-from-handler executes
//     pc_plus4 [31:0] in   PC+4 of the current instruction
//     er_write        out  write strobe to the exception-target register
//     er_o     [4:0]  out  target register index (K0_REG once used)
//     epc_o    [31:0] out  latched return address
//     pc_redirect     out  one-cycle strobe: load PC with handler_pc
//     handler_pc[31:0]out  handler vector address
//     kernel_mode     out  high while executing a handler
//     abort_inst      out  one-cycle strobe: discard current instruction
// ---------------------------------------------------------------------------
module exception_unit
  import exception_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        irq,
  input  logic        undef_inst,
  input  logic        instr_boundary,
  input  logic        eret,
  input  logic [31:0] pc_plus4,
  output logic        er_write,
  output logic [4:0]  er_o,
  output logic [31:0] epc_o,
  output logic        pc_redirect,
  output logic [31:0] handler_pc,
  output logic        kernel_mode,
  output logic        abort_inst
);

  state_t state;
  state_t state_next;
  cause_t cause;        // cause of the exception currently being entered
  cause_t take_cause;   // cause selected this cycle when take is asserted
  logic   take;         // enter TAKE on the next edge
  logic   leave_kernel; // eret accepted this cycle
  logic   irq_s;
  logic   irq_pend;

  exception_unit_irq_sync u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .d     (irq),
    .q     (irq_s)
  );

  // NOTE: reset is asynchronous; the strobes below decode the state register
  // combinationally, so asserting reset mid-TAKE drops them at once rather
  // than at the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= USER;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and strobe decode.
  // NOTE: every signal written here gets a default first; any path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_next   = state;
    take         = 1'b0;
    take_cause   = ILLOP;
    leave_kernel = 1'b0;
    er_write     = 1'b0;
    pc_redirect  = 1'b0;
    abort_inst   = 1'b0;

    unique case (state)
      USER: begin
        // An illegal instruction beats a pending interrupt in the same cycle;
        // the interrupt stays pending and is retaken later.
        if (undef_inst) begin
          take       = 1'b1;
          take_cause = ILLOP;
        end else if (instr_boundary && irq_pend) begin
          take       = 1'b1;
          take_cause = XADR;
        end
      end

      TAKE: begin
        // Single strobe cycle; instr_boundary, undef_inst and eret are ignored.
        er_write    = 1'b1;
        pc_redirect = 1'b1;
        abort_inst  = (cause == ILLOP);
        state_next  = KERNEL;
      end

      KERNEL: begin
        // Interrupts are masked here. A nested illegal instruction wins over
        // a simultaneous eret.
        if (undef_inst) begin
          take       = 1'b1;
          take_cause = ILLOP;
        end else if (eret) begin
          leave_kernel = 1'b1;
          state_next   = USER;
        end
      end

      default: begin
        state_next = USER;
      end
    endcase

    if (take) begin
      state_next = TAKE;
    end
  end

  // Exception context: captured on the decision cycle so it is stable for
  // the whole TAKE cycle and held afterwards. er_o is never cleared except
  // by reset; er_write alone qualifies it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cause      <= ILLOP;
      epc_o      <= '0;
      handler_pc <= '0;
      er_o       <= '0;
    end else if (take) begin
      cause      <= take_cause;
      epc_o      <= pc_plus4;
      handler_pc <= vector_for(take_cause);
      er_o       <= K0_REG;
    end
  end

  // kernel_mode rises as TAKE hands over to KERNEL and stays high across a
  // nested TAKE; it falls only when eret is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kernel_mode <= 1'b0;
    end else if (state == TAKE) begin
      kernel_mode <= 1'b1;
    end else if (leave_kernel) begin
      kernel_mode <= 1'b0;
    end
  end

  // Pending interrupt latch. Only taking the interrupt clears it; a dropped
  // irq does not. The clear wins over a simultaneous set so a taken request
  // is not immediately retaken from the same synchroniser sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_pend <= 1'b0;
    end else if (take && (take_cause == XADR)) begin
      irq_pend <= 1'b0;
    end else if (irq_s) begin
      irq_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_exception_unit.sv
// ---------------------------------------------------------------------------
// tb_exception_unit
//   Directed stimulus for exception_unit. Each stimulus that must cause an
//   exception pushes the expected TAKE-cycle contents into a queue; a monitor
//   sampling 1 ns after every rising edge pops and compares whenever the DUT
//   asserts er_write, and flags any strobe that nothing expected.
// ---------------------------------------------------------------------------
module tb_exception_unit;
  import exception_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        irq;
  logic        undef_inst;
  logic        instr_boundary;
  logic        eret;
  logic [31:0] pc_plus4;
  logic        er_write;
  logic [4:0]  er_o;
  logic [31:0] epc_o;
  logic        pc_redirect;
  logic [31:0] handler_pc;
  logic        kernel_mode;
  logic        abort_inst;

  exception_unit dut (
    .clk            (clk),
    .reset          (reset),
    .irq            (irq),
    .undef_inst     (undef_inst),
    .instr_boundary (instr_boundary),
    .eret           (eret),
    .pc_plus4       (pc_plus4),
    .er_write       (er_write),
    .er_o           (er_o),
    .epc_o          (epc_o),
    .pc_redirect    (pc_redirect),
    .handler_pc     (handler_pc),
    .kernel_mode    (kernel_mode),
    .abort_inst     (abort_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [31:0] epc;
    logic [31:0] vec;
    logic        abort;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs on the falling edge.
  task automatic step(input logic u, input logic b, input logic e, input logic [31:0] pc);
    @(negedge clk);
    undef_inst     = u;
    instr_boundary = b;
    eret           = e;
    pc_plus4       = pc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Called right after a step(): the TAKE strobes are due one edge later.
  task automatic expect_take(input logic [31:0] epc, input logic [31:0] vec, input logic abort);
    exp_t e;
    e.cyc   = cyc + 1;
    e.epc   = epc;
    e.vec   = vec;
    e.abort = abort;
    sb.push_back(e);
  endtask

  task automatic irq_pulse(input int n);
    irq = 1'b1;
    idle(n);
    irq = 1'b0;
  endtask

  // Monitor: compares every strobe against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        if (er_write) begin
          if (sb.size() == 0) begin
            check("unexpected_strobe", {31'b0, er_write}, 32'h0);
          end else begin
            e = sb.pop_front();
            check("take_cycle",  e.cyc, cyc);
            check("er_o",        {27'b0, er_o}, {27'b0, K0_REG});
            check("epc_o",       epc_o, e.epc);
            check("handler_pc",  handler_pc, e.vec);
            check("pc_redirect", {31'b0, pc_redirect}, 32'h1);
            check("abort_inst",  {31'b0, abort_inst}, {31'b0, e.abort});
          end
        end else if (pc_redirect || abort_inst) begin
          check("stray_strobe", {30'b0, pc_redirect, abort_inst}, 32'h0);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; irq = 1'b0; undef_inst = 1'b0;
    instr_boundary = 1'b0; eret = 1'b0; pc_plus4 = 32'h0;

    // Reset state.
    #12;
    check("rst_er_write",    {31'b0, er_write}, 32'h0);
    check("rst_er_o",        {27'b0, er_o}, 32'h0);
    check("rst_epc_o",       epc_o, 32'h0);
    check("rst_handler_pc",  handler_pc, 32'h0);
    check("rst_kernel_mode", {31'b0, kernel_mode}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    idle(3);

    // Undef in USER.
    step(1'b1, 1'b0, 1'b0, 32'h0000_0044);
    expect_take(32'h0000_0044, ILLOP_VEC, 1'b1);
    idle(1);
    check("km_during_take", {31'b0, kernel_mode}, 32'h0);
    idle(1);
    check("km_after_undef", {31'b0, kernel_mode}, 32'h1);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    idle(1);
    check("km_after_eret", {31'b0, kernel_mode}, 32'h0);

    // IRQ waits for an instruction boundary.
    irq_pulse(3);
    idle(10);
    check("er_o_held", {27'b0, er_o}, {27'b0, K0_REG});
    step(1'b0, 1'b1, 1'b0, 32'h0000_0100);
    expect_take(32'h0000_0100, XADR_VEC, 1'b0);
    idle(2);
    check("km_after_irq", {31'b0, kernel_mode}, 32'h1);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    idle(1);
    // Pending was cleared by the take: a boundary must not retake.
    step(1'b0, 1'b1, 1'b0, 32'h0000_1234);
    idle(3);

    // IRQ masked in KERNEL; eret cycle must not take it even with a boundary.
    step(1'b1, 1'b0, 1'b0, 32'h0000_0060);
    expect_take(32'h0000_0060, ILLOP_VEC, 1'b1);
    idle(2);
    irq_pulse(3);
    step(1'b0, 1'b1, 1'b0, 32'h0000_0500);
    idle(5);
    check("km_masked", {31'b0, kernel_mode}, 32'h1);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0204);
    idle(1);
    check("km_after_eret2", {31'b0, kernel_mode}, 32'h0);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 32'h0000_0200);
    expect_take(32'h0000_0200, XADR_VEC, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    idle(2);

    // Same-cycle priority: undef beats pending IRQ; IRQ retaken after eret.
    irq_pulse(3);
    idle(4);
    step(1'b1, 1'b1, 1'b0, 32'h0000_0300);
    expect_take(32'h0000_0300, ILLOP_VEC, 1'b1);
    idle(2);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 32'h0000_0304);
    expect_take(32'h0000_0304, XADR_VEC, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    idle(2);

    // Nested undef in KERNEL, then undef beating a simultaneous eret.
    step(1'b1, 1'b0, 1'b0, 32'h0000_0070);
    expect_take(32'h0000_0070, ILLOP_VEC, 1'b1);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 32'h8000_0010);
    expect_take(32'h8000_0010, ILLOP_VEC, 1'b1);
    idle(1);
    check("km_nested_take", {31'b0, kernel_mode}, 32'h1);
    idle(1);
    check("epc_nested", epc_o, 32'h8000_0010);
    step(1'b1, 1'b0, 1'b1, 32'h8000_0020);
    expect_take(32'h8000_0020, ILLOP_VEC, 1'b1);
    idle(2);
    check("km_undef_over_eret", {31'b0, kernel_mode}, 32'h1);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    idle(1);
    check("km_back_user", {31'b0, kernel_mode}, 32'h0);

    // Reset mid-TAKE with an IRQ pending: strobes drop at once, pending lost.
    irq_pulse(3);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 32'h0000_0090);
    expect_take(32'h0000_0090, ILLOP_VEC, 1'b1);
    @(negedge clk);
    undef_inst = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_mid_er_write",    {31'b0, er_write}, 32'h0);
    check("rst_mid_pc_redirect", {31'b0, pc_redirect}, 32'h0);
    check("rst_mid_abort",       {31'b0, abort_inst}, 32'h0);
    check("rst_mid_er_o",        {27'b0, er_o}, 32'h0);
    check("rst_mid_epc_o",       epc_o, 32'h0);
    check("rst_mid_handler_pc",  handler_pc, 32'h0);
    check("rst_mid_kernel_mode", {31'b0, kernel_mode}, 32'h0);
    idle(2);
    reset = 1'b0;
    idle(2);
    step(1'b0, 1'b1, 1'b0, 32'h0000_0400);
    idle(4);

    check("missing_strobes", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
